// File: rtl/apb_requester.sv
// Single-outstanding APB initiator: takes commands on a valid/ready channel, runs the
// SETUP/ACCESS handshake with a bounded wait, and returns a registered response.
module apb_requester #(
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 8,
   parameter int TIMEOUT = 16
) (
   input  logic              pclk,
   input  logic              preset,

   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,

   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              rsp_timeout,

   output logic              psel,
   output logic              penable,
   output logic              pwrite,
   output logic [ADDR_W-1:0] paddr,
   output logic [DATA_W-1:0] pwdata,
   input  logic [DATA_W-1:0] prdata,
   input  logic              pready,
   input  logic              pslverr
);

   localparam int              CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;
   logic             accept;
   logic             done_ok;
   logic             done_to;
   logic             psel_nxt;
   logic             penable_nxt;

   // A pending response blocks new commands, so consume and accept never share an edge.
   assign cmd_ready = (state == IDLE) && !rsp_valid;

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path leaves one
      // unassigned and no latch is inferred.
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      accept       = 1'b0;
      done_ok      = 1'b0;
      done_to      = 1'b0;

      unique case (state)
         IDLE: begin
            if (cmd_valid && cmd_ready) begin
               accept    = 1'b1;
               state_nxt = SETUP;
            end
         end
         SETUP: begin
            wait_cnt_nxt = '0;
            state_nxt    = ACCESS;
         end
         ACCESS: begin
            if (pready) begin
               done_ok   = 1'b1;
               state_nxt = IDLE;
            end else if (wait_cnt == CNT_LAST) begin
               done_to   = 1'b1;
               state_nxt = IDLE;
            end else begin
               // Below CNT_LAST here, so the increment cannot wrap.
               wait_cnt_nxt = wait_cnt + CNT_W'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase

      // APB strobes are registered from the next state so they never glitch on decode.
      psel_nxt    = (state_nxt != IDLE);
      penable_nxt = (state_nxt == ACCESS);
   end

   always_ff @(posedge pclk or posedge preset) begin
      // NOTE: flops are written with non-blocking assignments so every one of them
      // samples the values from before the edge.
      if (preset) begin
         state    <= IDLE;
         wait_cnt <= '0;
         psel     <= 1'b0;
         penable  <= 1'b0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
         psel     <= psel_nxt;
         penable  <= penable_nxt;
      end
   end

   // Address/direction/data are loaded only at acceptance and then held through the transfer.
   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         pwrite <= 1'b0;
         paddr  <= '0;
         pwdata <= '0;
      end else if (accept) begin
         pwrite <= cmd_write;
         paddr  <= cmd_addr;
         pwdata <= cmd_write ? cmd_wdata : '0;
      end
   end

   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         rsp_valid   <= 1'b0;
         rsp_rdata   <= '0;
         rsp_err     <= 1'b0;
         rsp_timeout <= 1'b0;
      end else if (done_ok) begin
         rsp_valid   <= 1'b1;
         rsp_rdata   <= pwrite ? '0 : prdata;
         rsp_err     <= pslverr;
         rsp_timeout <= 1'b0;
      end else if (done_to) begin
         rsp_valid   <= 1'b1;
         rsp_rdata   <= '0;
         rsp_err     <= 1'b1;
         rsp_timeout <= 1'b1;
      end else if (rsp_valid && rsp_ready) begin
         rsp_valid   <= 1'b0;
         rsp_rdata   <= '0;
         rsp_err     <= 1'b0;
         rsp_timeout <= 1'b0;
      end
   end

endmodule

// File: tb/tb_apb_requester.sv
// Randomized bench for apb_requester: a stimulus driver and APB slave feed a scoreboard
// whose monitor checks the APB phases, latency and every response against a reference model.
module tb_apb_requester;

   localparam int TIMEOUT = 16;

   typedef struct {
      int         waits;
      logic       err;
      logic [7:0] data;
   } plan_t;

   typedef struct {
      logic       write;
      logic [7:0] addr;
      logic [7:0] wdata;
      logic [7:0] rdata;
      logic       err;
      logic       to;
      int         acc;
      longint     t_acc;
   } exp_t;

   logic       pclk = 1'b0;
   logic       preset = 1'b1;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic       cmd_write = 1'b0;
   logic [7:0] cmd_addr = 8'h00;
   logic [7:0] cmd_wdata = 8'h00;
   logic       rsp_valid;
   logic       rsp_ready = 1'b0;
   logic [7:0] rsp_rdata;
   logic       rsp_err;
   logic       rsp_timeout;
   logic       psel;
   logic       penable;
   logic       pwrite;
   logic [7:0] paddr;
   logic [7:0] pwdata;
   logic [7:0] prdata = 8'h00;
   logic       pready = 1'b0;
   logic       pslverr = 1'b0;

   int     total = 0;
   int     bad = 0;
   longint cyc = 0;
   longint last_t_acc = 0;
   int     rr_mode = 0;
   int     acc_mon = 0;
   logic   prev_rv = 1'b0;
   logic   prev_setup = 1'b0;
   logic   in_access = 1'b0;
   plan_t  plan_q[$];
   exp_t   exp_q[$];

   apb_requester #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(TIMEOUT)) dut (
      .pclk(pclk), .preset(preset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
      .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
      .prdata(prdata), .pready(pready), .pslverr(pslverr)
   );

   always #5 pclk = ~pclk;
   always @(posedge pclk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, want, $time);
      end
   endtask

   // Reference model: what the transfer must return, from the command and the slave's behaviour.
   function automatic exp_t model(input logic w, input logic [7:0] a, input logic [7:0] d,
                                  input plan_t p);
      exp_t e;
      e.write = w;
      e.addr  = a;
      e.wdata = w ? d : 8'h00;
      e.t_acc = 0;
      if (p.waits >= TIMEOUT) begin
         e.acc = TIMEOUT; e.err = 1'b1; e.to = 1'b1; e.rdata = 8'h00;
      end else begin
         e.acc = p.waits + 1; e.err = p.err; e.to = 1'b0; e.rdata = w ? 8'h00 : p.data;
      end
      return e;
   endfunction

   task automatic issue(input logic w, input logic [7:0] a, input logic [7:0] d,
                        input int waits, input logic serr, input logic [7:0] rd);
      plan_t p;
      exp_t  e;
      int    budget = 0;
      cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
      while (!cmd_ready && budget < 100) begin
         @(negedge pclk);
         budget++;
      end
      if (!cmd_ready) begin
         check("cmd_accept", 32'(cmd_ready), 1);
         cmd_valid = 1'b0;
         return;
      end
      p.waits = waits; p.err = serr; p.data = rd;
      e = model(w, a, d, p);
      e.t_acc = cyc + 1;
      last_t_acc = e.t_acc;
      plan_q.push_back(p);
      exp_q.push_back(e);
      @(negedge pclk);
      // Scramble the command bus mid-transfer; the APB side must ignore it.
      cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_addr = 8'($urandom); cmd_wdata = 8'($urandom);
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         @(negedge pclk);
         n++;
      end
      check("drain", 32'(exp_q.size()), 0);
   endtask

   // Response consumer: always ready, random, or held off.
   initial begin
      forever begin
         @(posedge pclk);
         #1;
         case (rr_mode)
            0:       rsp_ready = 1'b1;
            1:       rsp_ready = 1'($urandom_range(0, 1));
            default: rsp_ready = 1'b0;
         endcase
      end
   end

   // APB slave: follows the plan for each transfer, noise on prdata/pslverr otherwise.
   initial begin
      plan_t cur;
      int    acc_cnt = 0;
      cur.waits = 0; cur.err = 1'b0; cur.data = 8'h00;
      forever begin
         @(negedge pclk);
         if (psel && penable) begin
            if (!in_access) begin
               in_access = 1'b1;
               acc_cnt = 0;
               if (plan_q.size() == 0) check("slave_plan", 32'(plan_q.size()), 1);
               else cur = plan_q.pop_front();
            end else begin
               acc_cnt++;
            end
            pready = (acc_cnt == cur.waits);
         end else begin
            in_access = 1'b0;
            pready = 1'($urandom_range(0, 1));
         end
         prdata  = pready && psel && penable ? cur.data : 8'($urandom);
         pslverr = pready && psel && penable ? cur.err  : 1'($urandom);
      end
   end

   // Monitor / scoreboard.
   initial begin
      exp_t e;
      forever begin
         @(negedge pclk);
         if (!preset) begin
            if (penable) check("penable_has_psel", 32'(psel), 1);
            if (prev_setup) check("setup_then_access", {30'd0, psel, penable}, 3);
            prev_setup = psel && !penable;
            if (psel) begin
               if (exp_q.size() == 0) check("apb_cmd_pending", 32'(exp_q.size()), 1);
               else begin
                  e = exp_q[0];
                  check("pwrite", 32'(pwrite), 32'(e.write));
                  check("paddr", 32'(paddr), 32'(e.addr));
                  check("pwdata", 32'(pwdata), 32'(e.wdata));
               end
               if (penable) acc_mon++;
            end
            if (rsp_valid) begin
               if (exp_q.size() == 0) check("rsp_expected", 32'(exp_q.size()), 1);
               else begin
                  e = exp_q[0];
                  if (!prev_rv) begin
                     check("latency", 32'(cyc), 32'(e.t_acc + 1 + longint'(e.acc)));
                     check("access_cycles", 32'(acc_mon), 32'(e.acc));
                     acc_mon = 0;
                  end
                  check("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
                  check("rsp_err", 32'(rsp_err), 32'(e.err));
                  check("rsp_timeout", 32'(rsp_timeout), 32'(e.to));
                  check("cmd_ready_blocked", 32'(cmd_ready), 0);
                  if (rsp_ready) void'(exp_q.pop_front());
               end
            end
            prev_rv = rsp_valid && !rsp_ready;
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic       w;
      logic       serr;
      logic [7:0] a, d, rd;
      int         waits;
      longint     t1;
      int         n;

      repeat (2) @(posedge pclk);
      #1;
      check("rst_psel", 32'(psel), 0);
      check("rst_penable", 32'(penable), 0);
      check("rst_pwrite", 32'(pwrite), 0);
      check("rst_paddr", 32'(paddr), 0);
      check("rst_pwdata", 32'(pwdata), 0);
      check("rst_rsp_valid", 32'(rsp_valid), 0);
      check("rst_rsp_rdata", 32'(rsp_rdata), 0);
      check("rst_rsp_err", 32'(rsp_err), 0);
      check("rst_rsp_timeout", 32'(rsp_timeout), 0);
      check("rst_cmd_ready", 32'(cmd_ready), 1);
      @(negedge pclk);
      preset = 1'b0;
      rr_mode = 0;
      @(negedge pclk);

      issue(1'b1, 8'h00, 8'h5A, 0, 1'b0, 8'hEE);     // zero-wait write
      drain();
      issue(1'b0, 8'h02, 8'h11, 3, 1'b0, 8'hC3);     // read, three wait states
      drain();
      issue(1'b1, 8'h7F, 8'h33, 0, 1'b1, 8'h00);     // slave error
      drain();
      issue(1'b0, 8'h04, 8'h00, 40, 1'b0, 8'hAA);    // pready stuck low
      drain();
      issue(1'b0, 8'h05, 8'h00, TIMEOUT - 1, 1'b0, 8'h3C); // ready on the last allowed cycle
      drain();

      // Hold off the response while the next command waits, then back-to-back issue.
      rr_mode = 2;
      issue(1'b1, 8'h10, 8'hA1, 0, 1'b0, 8'h00);
      fork
         begin
            repeat (7) @(negedge pclk);
            rr_mode = 0;
         end
         issue(1'b0, 8'h11, 8'h00, 0, 1'b0, 8'h42);
      join
      t1 = last_t_acc;
      issue(1'b1, 8'h12, 8'hB2, 0, 1'b0, 8'h00);
      check("issue_interval", 32'(last_t_acc - t1), 4);
      drain();

      rr_mode = 1;
      for (int i = 0; i < 40; i++) begin
         w    = 1'($urandom);
         a    = 8'($urandom);
         d    = 8'($urandom);
         rd   = 8'($urandom);
         serr = ($urandom_range(0, 3) == 0);
         waits = ($urandom_range(0, 7) == 0) ? int'($urandom_range(TIMEOUT - 2, TIMEOUT + 2))
                                             : int'($urandom_range(0, 4));
         repeat ($urandom_range(0, 2)) @(negedge pclk);
         issue(w, a, d, waits, serr, rd);
      end
      drain();

      // Asynchronous reset during an ACCESS wait state.
      rr_mode = 0;
      issue(1'b0, 8'h20, 8'h00, 12, 1'b0, 8'h77);
      n = 0;
      while (acc_mon < 3 && n < 50) begin
         @(negedge pclk);
         n++;
      end
      check("reached_access", 32'(acc_mon >= 3), 1);
      @(posedge pclk);
      #2;
      preset = 1'b1;
      #1;
      check("areset_psel", 32'(psel), 0);
      check("areset_penable", 32'(penable), 0);
      check("areset_rsp_valid", 32'(rsp_valid), 0);
      exp_q.delete();
      plan_q.delete();
      acc_mon = 0; prev_rv = 1'b0; prev_setup = 1'b0; in_access = 1'b0;
      repeat (2) @(posedge pclk);
      #2;
      preset = 1'b0;
      @(negedge pclk);
      check("post_reset_cmd_ready", 32'(cmd_ready), 1);
      issue(1'b0, 8'h01, 8'h00, 1, 1'b0, 8'h96);
      drain();
      check("plan_drain", 32'(plan_q.size()), 0);

      repeat (3) @(negedge pclk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
